vram_arbiter: RTL

VRAM_ARBITER -- requirements
Module: vram_arbiter

---
 rtl/vram_arbiter_if.sv | 41 ++++
 rtl/vram_arbiter.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/vram_arbiter_if.sv
// Bundle of video timing, host write, clear control and RAM port signals
// shared between the VRAM arbiter and its surroundings.
`timescale 1ns/1ps
interface vram_arbiter_if #(
    parameter int ADDR_W = 15
);
    logic              tick;
    logic              video_on;
    logic [9:0]        pixelx;
    logic [9:0]        pixely;
    logic              wr_valid;
    logic [ADDR_W-1:0] wr_addr;
    logic [7:0]        wr_data;
    logic              wr_ready;
    logic              wr_err;
    logic              clr_req;
    logic [7:0]        clr_color;
    logic              busy;
    logic              clr_done;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_we;
    logic [7:0]        mem_wdata;
    logic [7:0]        mem_rdata;
    logic [7:0]        pixel_data;

    modport slave (
        input  tick, video_on, pixelx, pixely,
        input  wr_valid, wr_addr, wr_data,
        input  clr_req, clr_color, mem_rdata,
        output wr_ready, wr_err, busy, clr_done,
        output mem_addr, mem_we, mem_wdata, pixel_data
    );

    modport master (
        output tick, video_on, pixelx, pixely,
        output wr_valid, wr_addr, wr_data,
        output clr_req, clr_color, mem_rdata,
        input  wr_ready, wr_err, busy, clr_done,
        input  mem_addr, mem_we, mem_wdata, pixel_data
    );
endinterface

// File: rtl/vram_arbiter.sv
// Single-port VRAM arbiter: display reads always win, free cycles go to a
// framebuffer clear or to the buffered host write stream.
`timescale 1ns/1ps
module vram_arbiter #(
    parameter int FB_W            = 160,
    parameter int FB_H            = 120,
    parameter int SCALE_SHIFT     = 2,
    parameter int ADDR_W          = 15,
    parameter int FIFO_DEPTH      = 4,
    parameter int WRITE_IN_ACTIVE = 1
) (
    input logic           clk,
    input logic           reset,
    vram_arbiter_if.slave bus
);

    localparam int                PTR_W   = $clog2(FIFO_DEPTH);
    localparam int                CELLS   = FB_W * FB_H;
    localparam logic [ADDR_W:0]   CELLS_X = (ADDR_W + 1)'(CELLS);
    localparam logic [ADDR_W-1:0] LAST_A  = ADDR_W'(CELLS - 1);
    localparam logic [ADDR_W-1:0] FB_W_A  = ADDR_W'(FB_W);
    localparam logic [PTR_W:0]    DEPTH_C = (PTR_W + 1)'(FIFO_DEPTH);

    typedef enum logic {IDLE, CLEAR} state_t;

    state_t            state, state_nx;
    logic              disp_slot, free_slot;
    logic [ADDR_W-1:0] disp_addr;

    logic [ADDR_W-1:0] fifo_addr [FIFO_DEPTH];
    logic [7:0]        fifo_data [FIFO_DEPTH];
    logic [PTR_W-1:0]  rd_ptr, wr_ptr;
    logic [PTR_W:0]    count;
    logic              full, empty, push, pop, head_in_range;

    logic [ADDR_W-1:0] clr_ptr;
    logic [7:0]        clr_color_q;
    logic              clr_grant;

    logic [ADDR_W-1:0] mem_addr_p1;
    logic              mem_we_p1;
    logic [7:0]        mem_wdata_p1;
    logic              wr_err_p1, clr_done_p1;
    logic              vld_p1, rd_p1, vld_p2, rd_p2;
    logic [7:0]        pixel_p3;

    assign disp_slot = bus.tick & bus.video_on;
    assign free_slot = ~disp_slot;
    assign disp_addr = ADDR_W'(bus.pixely >> SCALE_SHIFT) * FB_W_A
                     + ADDR_W'(bus.pixelx >> SCALE_SHIFT);

    assign full          = (count == DEPTH_C);
    assign empty         = (count == '0);
    assign push          = bus.wr_valid & ~full;
    assign head_in_range = ({1'b0, fifo_addr[rd_ptr]} < CELLS_X);

    always_comb begin
        state_nx  = state;
        clr_grant = 1'b0;
        pop       = 1'b0;
        case (state)
            IDLE: begin
                pop = free_slot & ~empty & ((WRITE_IN_ACTIVE != 0) | ~bus.video_on);
                if (bus.clr_req) state_nx = CLEAR;
            end
            CLEAR: begin
                clr_grant = free_slot;
                if (free_slot && clr_ptr == LAST_A) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_addr[wr_ptr] <= bus.wr_addr;
            fifo_data[wr_ptr] <= bus.wr_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr       <= '0;
            wr_ptr       <= '0;
            count        <= '0;
            clr_ptr      <= '0;
            clr_color_q  <= '0;
            mem_addr_p1  <= '0;
            mem_we_p1    <= 1'b0;
            mem_wdata_p1 <= '0;
            wr_err_p1    <= 1'b0;
            clr_done_p1  <= 1'b0;
            vld_p1       <= 1'b0;
            rd_p1        <= 1'b0;
            vld_p2       <= 1'b0;
            rd_p2        <= 1'b0;
            pixel_p3     <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase

            if (state == IDLE && bus.clr_req) begin
                clr_ptr     <= '0;
                clr_color_q <= bus.clr_color;
            end else if (clr_grant) begin
                clr_ptr <= clr_ptr + 1'b1;
            end

            // stage p1: memory command; address/data hold when nothing is granted
            mem_we_p1   <= 1'b0;
            wr_err_p1   <= 1'b0;
            clr_done_p1 <= 1'b0;
            if (disp_slot) begin
                mem_addr_p1 <= disp_addr;
            end else if (clr_grant) begin
                mem_we_p1    <= 1'b1;
                mem_addr_p1  <= clr_ptr;
                mem_wdata_p1 <= clr_color_q;
                clr_done_p1  <= (clr_ptr == LAST_A);
            end else if (pop) begin
                if (head_in_range) begin
                    mem_we_p1    <= 1'b1;
                    mem_addr_p1  <= fifo_addr[rd_ptr];
                    mem_wdata_p1 <= fifo_data[rd_ptr];
                end else begin
                    wr_err_p1 <= 1'b1;
                end
            end
            vld_p1 <= bus.tick;
            rd_p1  <= bus.video_on;

            // stage p2: RAM data returns for the read issued in p1
            vld_p2 <= vld_p1;
            rd_p2  <= rd_p1;

            // stage p3: pixel register, blanked ticks load zero
            if (vld_p2) pixel_p3 <= rd_p2 ? bus.mem_rdata : 8'h00;
        end
    end

    assign bus.wr_ready   = ~full;
    assign bus.wr_err     = wr_err_p1;
    assign bus.busy       = (state == CLEAR);
    assign bus.clr_done   = clr_done_p1;
    assign bus.mem_addr   = mem_addr_p1;
    assign bus.mem_we     = mem_we_p1;
    assign bus.mem_wdata  = mem_wdata_p1;
    assign bus.pixel_data = pixel_p3;

endmodule
